fetch_queue_unit: RTL and testbench

- Parametrised multi-issue fetch stage for the RISC-V core; successor to the fixed dual-fetch stage with a 4/8 increment select.
- Each cycle it fetches ISSUE_WIDTH consecutive instructions from instruction memory and pushes them, tagged with their PCs, into a circular fetch queue.
- Decode drains the queue head at a variable rate of 0..ISSUE_WIDTH instructions per cycle.
- A redirect input (branch/jump resolution) flushes the queue and restarts fetch at a new PC.

---
 rtl/fetch_queue_unit.sv | 99 +++++++++
 tb/tb_fetch_queue_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Multi-issue fetch stage: fetches ISSUE_WIDTH consecutive words per cycle into a
// circular queue that decode drains from the head at 0..ISSUE_WIDTH entries per cycle.
module fetch_queue_unit #(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    ISSUE_WIDTH = 2,
   parameter int                    QUEUE_DEPTH = 8,
   parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   Redirect,
   input  logic [DATA_WIDTH-1:0]                  RedirectPC,
   output logic [DATA_WIDTH-1:0]                  ImemAddr,
   input  logic [ISSUE_WIDTH*DATA_WIDTH-1:0]      ImemData,
   input  logic [$clog2(ISSUE_WIDTH+1)-1:0]       PopCount,
   output logic [ISSUE_WIDTH*DATA_WIDTH-1:0]      InstrOut,
   output logic [ISSUE_WIDTH*DATA_WIDTH-1:0]      PCOut,
   output logic [ISSUE_WIDTH-1:0]                 ValidOut,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0]       Count
);

   localparam int CW = $clog2(QUEUE_DEPTH + 1);
   localparam int AW = $clog2(QUEUE_DEPTH);

   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [AW-1:0]         head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]         count_q, count_d;
   logic [CW-1:0]         pop_n;
   logic                  push;

   logic [DATA_WIDTH-1:0] instr_q [QUEUE_DEPTH];
   logic [DATA_WIDTH-1:0] pcs_q   [QUEUE_DEPTH];

   // Requests beyond the valid lanes or the issue width are clamped silently.
   always_comb begin
      pop_n = CW'(PopCount);
      if (pop_n > count_q)
         pop_n = count_q;
      if (pop_n > CW'(ISSUE_WIDTH))
         pop_n = CW'(ISSUE_WIDTH);
   end

   // Push decision looks only at the pre-pop occupancy, keeping PopCount off the fetch path.
   always_comb begin
      push    = !Redirect && (count_q <= CW'(QUEUE_DEPTH - ISSUE_WIDTH));
      pc_d    = pc_q;
      head_d  = head_q + AW'(pop_n);
      tail_d  = tail_q;
      count_d = count_q - pop_n;
      if (Redirect) begin
         pc_d    = RedirectPC & ~DATA_WIDTH'(3);
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else if (push) begin
         pc_d    = pc_q + DATA_WIDTH'(4 * ISSUE_WIDTH);
         tail_d  = tail_q + AW'(ISSUE_WIDTH);
         count_d = count_q - pop_n + CW'(ISSUE_WIDTH);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         pc_q    <= pc_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         for (int i = 0; i < ISSUE_WIDTH; i++) begin
            instr_q[tail_q + AW'(i)] <= ImemData[i*DATA_WIDTH +: DATA_WIDTH];
            pcs_q[tail_q + AW'(i)]   <= pc_q + DATA_WIDTH'(4 * i);
         end
      end
   end

   always_comb begin
      InstrOut = '0;
      PCOut    = '0;
      ValidOut = '0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         InstrOut[i*DATA_WIDTH +: DATA_WIDTH] = instr_q[head_q + AW'(i)];
         PCOut[i*DATA_WIDTH +: DATA_WIDTH]    = pcs_q[head_q + AW'(i)];
         ValidOut[i]                          = (count_q > CW'(i));
      end
   end

   assign ImemAddr = pc_q;
   assign Count    = count_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit (ISSUE_WIDTH=2, QUEUE_DEPTH=8): directed table, a steady-state
// wrap sequence, then randomized traffic against a queue-based reference model.
module tb_fetch_queue_unit;

   logic        clk = 1'b0;
   logic        rst, Redirect;
   logic [31:0] RedirectPC, ImemAddr;
   logic [63:0] ImemData, InstrOut, PCOut;
   logic [1:0]  PopCount, ValidOut;
   logic [3:0]  Count;
   logic [31:0] mask;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fetch_queue_unit #(
      .DATA_WIDTH(32), .ISSUE_WIDTH(2), .QUEUE_DEPTH(8), .RESET_PC(32'h0)
   ) dut (
      .clk(clk), .rst(rst), .Redirect(Redirect), .RedirectPC(RedirectPC),
      .ImemAddr(ImemAddr), .ImemData(ImemData), .PopCount(PopCount),
      .InstrOut(InstrOut), .PCOut(PCOut), .ValidOut(ValidOut), .Count(Count)
   );

   // Instruction memory: word(addr) = addr, optionally scrambled so data differs from PC.
   assign ImemData = {(ImemAddr + 32'd4) ^ mask, ImemAddr ^ mask};

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic cycle(input logic r, input logic rd, input logic [31:0] rpc, input logic [1:0] p);
      rst = r; Redirect = rd; RedirectPC = rpc; PopCount = p;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      int r; int rd; int rpc; int pop;
      int cnt; int addr; int vld; int l0; int l1;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input int r, input int rd, input int rpc, input int pop,
                      input int cnt, input int addr, input int vld, input int l0, input int l1);
      vec_t v;
      v = '{r, rd, rpc, pop, cnt, addr, vld, l0, l1};
      tbl.push_back(v);
   endtask

   // Reference model: plain queue of {instr, pc} plus a fetch PC.
   typedef struct packed { logic [31:0] instr; logic [31:0] pc; } ent_t;
   ent_t        mq[$];
   logic [31:0] mpc;

   task automatic model_step(input logic r, input logic rd, input logic [31:0] rpc, input int p);
      bit   do_push;
      int   n;
      ent_t e;
      if (r) begin
         mq.delete();
         mpc = 32'h0;
      end else if (rd) begin
         mq.delete();
         mpc = {rpc[31:2], 2'b00};
      end else begin
         do_push = (8 - mq.size()) >= 2;
         n = p;
         if (n > mq.size()) n = mq.size();
         if (n > 2) n = 2;
         repeat (n) void'(mq.pop_front());
         if (do_push) begin
            for (int i = 0; i < 2; i++) begin
               e.pc    = mpc + 32'(4 * i);
               e.instr = e.pc ^ mask;
               mq.push_back(e);
            end
            mpc = mpc + 32'd8;
         end
      end
   endtask

   task automatic model_check();
      chk("rnd_count", 64'(Count), 64'(mq.size()));
      chk("rnd_addr", 64'(ImemAddr), 64'(mpc));
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rnd_valid%0d", i), 64'(ValidOut[i]), 64'(mq.size() > i));
         if (mq.size() > i) begin
            chk($sformatf("rnd_instr%0d", i), 64'(InstrOut[i*32 +: 32]), 64'(mq[i].instr));
            chk($sformatf("rnd_pc%0d", i), 64'(PCOut[i*32 +: 32]), 64'(mq[i].pc));
         end
      end
   endtask

   initial begin
      logic       r, rd;
      logic [31:0] rpc;
      logic [1:0]  p;

      rst = 1'b1; Redirect = 1'b0; RedirectPC = '0; PopCount = '0; mask = '0;

      //   rst rd  rpc    pop cnt addr   vld l0     l1
      add(1, 0, 0,     0, 0, 0,     0, 0,     0);
      add(0, 0, 0,     0, 2, 8,     3, 0,     4);
      add(0, 0, 0,     0, 4, 16,    3, 0,     4);
      add(0, 0, 0,     0, 6, 24,    3, 0,     4);
      add(0, 0, 0,     0, 8, 32,    3, 0,     4);
      add(0, 0, 0,     0, 8, 32,    3, 0,     4);
      add(0, 0, 0,     1, 7, 32,    3, 4,     8);
      add(0, 0, 0,     1, 6, 32,    3, 8,     12);
      add(0, 0, 0,     0, 8, 40,    3, 8,     12);
      add(0, 0, 0,     3, 6, 40,    3, 16,    20);
      add(0, 0, 0,     2, 6, 48,    3, 24,    28);
      add(0, 1, 'h103, 2, 0, 'h100, 0, 0,     0);
      add(0, 0, 0,     2, 2, 'h108, 3, 'h100, 'h104);
      add(0, 0, 0,     2, 2, 'h110, 3, 'h108, 'h10c);
      add(0, 0, 0,     2, 2, 'h118, 3, 'h110, 'h114);
      add(0, 0, 0,     0, 4, 'h120, 3, 'h110, 'h114);
      add(0, 0, 0,     0, 6, 'h128, 3, 'h110, 'h114);
      add(0, 0, 0,     0, 8, 'h130, 3, 'h110, 'h114);
      add(0, 0, 0,     1, 7, 'h130, 3, 'h114, 'h118);
      add(0, 0, 0,     2, 5, 'h130, 3, 'h11c, 'h120);
      add(1, 1, 'h200, 2, 0, 0,     0, 0,     0);
      add(0, 0, 0,     0, 2, 8,     3, 0,     4);

      foreach (tbl[k]) begin
         cycle(1'(tbl[k].r), 1'(tbl[k].rd), 32'(tbl[k].rpc), 2'(tbl[k].pop));
         chk($sformatf("row%0d_count", k), 64'(Count), 64'(tbl[k].cnt));
         chk($sformatf("row%0d_addr", k), 64'(ImemAddr), 64'(tbl[k].addr));
         chk($sformatf("row%0d_valid", k), 64'(ValidOut), 64'(tbl[k].vld));
         if (tbl[k].vld[0]) begin
            chk($sformatf("row%0d_instr0", k), 64'(InstrOut[31:0]), 64'(tbl[k].l0));
            chk($sformatf("row%0d_pc0", k), 64'(PCOut[31:0]), 64'(tbl[k].l0));
         end
         if (tbl[k].vld[1]) begin
            chk($sformatf("row%0d_instr1", k), 64'(InstrOut[63:32]), 64'(tbl[k].l1));
            chk($sformatf("row%0d_pc1", k), 64'(PCOut[63:32]), 64'(tbl[k].l1));
         end
      end

      // Steady drain at full rate: occupancy stays at 2 while both pointers wrap.
      cycle(1'b1, 1'b0, 32'h0, 2'd0);
      for (int k = 1; k <= 6; k++) begin
         cycle(1'b0, 1'b0, 32'h0, 2'd2);
         chk($sformatf("steady%0d_count", k), 64'(Count), 64'd2);
         chk($sformatf("steady%0d_addr", k), 64'(ImemAddr), 64'(8 * k));
         chk($sformatf("steady%0d_valid", k), 64'(ValidOut), 64'd3);
         chk($sformatf("steady%0d_instr", k), 64'(InstrOut), {32'(8 * k - 4), 32'(8 * k - 8)});
         chk($sformatf("steady%0d_pc", k), 64'(PCOut), {32'(8 * k - 4), 32'(8 * k - 8)});
      end

      // Randomized traffic with scrambled memory data.
      mask = 32'h5A5A_5A5A;
      cycle(1'b1, 1'b0, 32'h0, 2'd0);
      model_step(1'b1, 1'b0, 32'h0, 0);
      for (int k = 0; k < 400; k++) begin
         r   = ($urandom_range(0, 63) == 0);
         rd  = ($urandom_range(0, 15) == 0);
         rpc = $urandom;
         p   = 2'($urandom_range(0, 3));
         model_check();
         model_step(r, rd, rpc, int'(p));
         cycle(r, rd, rpc, p);
      end
      model_check();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
